// File: rtl/cache_pkg.sv
// Shared constants, refill FSM state type and address-field helpers for the
// cache refill path. Address layout: {tag, index, word offset, byte offset}.
package cache_pkg;

   localparam int INDEX_WIDTH     = 8;
   localparam int OFFSET_WIDTH    = 4;
   localparam int TAG_WIDTH       = 32 - INDEX_WIDTH - OFFSET_WIDTH;
   localparam int WORD_SEL_WIDTH  = OFFSET_WIDTH - 2;
   localparam int LINE_WORDS      = 1 << WORD_SEL_WIDTH;
   localparam int DATA_ADDR_WIDTH = INDEX_WIDTH + WORD_SEL_WIDTH;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RECV,
      TAG
   } refill_state_t;

   function automatic logic [TAG_WIDTH-1:0] addr_tag(input logic [31:0] addr);
      return addr[31 -: TAG_WIDTH];
   endfunction

   function automatic logic [INDEX_WIDTH-1:0] addr_index(input logic [31:0] addr);
      return addr[OFFSET_WIDTH +: INDEX_WIDTH];
   endfunction

   function automatic logic [WORD_SEL_WIDTH-1:0] addr_word(input logic [31:0] addr);
      return addr[2 +: WORD_SEL_WIDTH];
   endfunction

endpackage

// File: rtl/refill_beat_cnt.sv
// Beat counter for one line refill: cleared when the burst is granted,
// advanced on each accepted beat, with a sticky ret_last/count mismatch flag.
module refill_beat_cnt
   import cache_pkg::*;
(
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      clr,
   input  logic                      beat,
   input  logic                      last_flag,
   output logic [WORD_SEL_WIDTH-1:0] cnt,
   output logic                      is_last,
   output logic                      err
);

   assign is_last = (cnt == WORD_SEL_WIDTH'(LINE_WORDS - 1));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt <= '0;
         err <= 1'b0;
      end else begin
         if (clr)
            cnt <= '0;
         else if (beat)
            cnt <= cnt + 1'b1;
         // The counter decides where the line ends; ret_last is only cross-checked.
         if (beat && (last_flag != is_last))
            err <= 1'b1;
      end
   end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Cache miss refill controller: burst-reads a line and installs data then tag.
// Optional critical-word forwarding is enabled by REFILL_CRITICAL_WORD_FWD_EN.
module cache_refill_ctrl
   import cache_pkg::*;
(
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       miss_valid,
   output logic                       miss_ready,
   input  logic [31:0]                miss_addr,
   output logic                       rd_req,
   input  logic                       rd_rdy,
   output logic [31:0]                rd_addr,
   input  logic                       ret_valid,
   input  logic                       ret_last,
   input  logic [31:0]                ret_data,
   output logic                       data_we,
   output logic [DATA_ADDR_WIDTH-1:0] data_addr,
   output logic [31:0]                data_wdata,
   output logic                       tag_we,
   output logic [INDEX_WIDTH-1:0]     tag_addr,
   output logic [TAG_WIDTH:0]         tag_wdata,
   output logic                       refill_done,
   output logic                       fwd_valid,
   output logic [31:0]                fwd_data,
   output logic                       err
);

   refill_state_t               state, state_nxt;
   logic [TAG_WIDTH-1:0]        tag_q;
   logic [INDEX_WIDTH-1:0]      index_q;
   logic [WORD_SEL_WIDTH-1:0]   cnt;
   logic                        cnt_last;
   logic                        accept, grant, beat, line_end;

   assign accept   = (state == IDLE) && miss_valid;
   assign grant    = (state == REQ) && rd_rdy;
   assign beat     = (state == RECV) && ret_valid;
   assign line_end = beat && cnt_last;

   refill_beat_cnt u_beat_cnt (
      .clk       (clk),
      .resetn    (resetn),
      .clr       (grant),
      .beat      (beat),
      .last_flag (ret_last),
      .cnt       (cnt),
      .is_last   (cnt_last),
      .err       (err)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // NOTE: defaults first so every path assigns every output (no latches).
   always_comb begin
      state_nxt  = state;
      miss_ready = 1'b0;
      rd_req     = 1'b0;
      case (state)
         IDLE: begin
            miss_ready = 1'b1;
            if (miss_valid)
               state_nxt = REQ;
         end
         REQ: begin
            rd_req = 1'b1;
            if (rd_rdy)
               state_nxt = RECV;
         end
         RECV: begin
            if (line_end)
               state_nxt = TAG;
         end
         TAG:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: data-path registers are reset as well, because reset values are
   // visible on the ports; the RAMs themselves are never cleared here.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tag_q       <= '0;
         index_q     <= '0;
         rd_addr     <= '0;
         data_we     <= 1'b0;
         data_addr   <= '0;
         data_wdata  <= '0;
         tag_we      <= 1'b0;
         tag_addr    <= '0;
         tag_wdata   <= '0;
         refill_done <= 1'b0;
      end else begin
         data_we     <= beat;
         tag_we      <= line_end;
         refill_done <= line_end;
         if (accept) begin
            tag_q   <= addr_tag(miss_addr);
            index_q <= addr_index(miss_addr);
            rd_addr <= {addr_tag(miss_addr), addr_index(miss_addr), {OFFSET_WIDTH{1'b0}}};
         end
         if (beat) begin
            data_wdata <= ret_data;
            data_addr  <= {index_q, cnt};
         end
         // Tag lands on the same edge as the last data word, never earlier.
         if (line_end) begin
            tag_addr  <= index_q;
            tag_wdata <= {1'b1, tag_q};
         end
      end
   end

`ifdef REFILL_CRITICAL_WORD_FWD_EN
   logic [WORD_SEL_WIDTH-1:0] word_q;
   logic                      crit_beat;

   assign crit_beat = beat && (cnt == word_q);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         word_q    <= '0;
         fwd_valid <= 1'b0;
         fwd_data  <= '0;
      end else begin
         fwd_valid <= crit_beat;
         if (accept)
            word_q <= addr_word(miss_addr);
         if (crit_beat)
            fwd_data <= ret_data;
      end
   end
`else
   assign fwd_valid = 1'b0;
   assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: directed scenarios plus random
// refills checked against an address/data model of the line installation.
module tb_cache_refill_ctrl;
   import cache_pkg::*;

   logic                       clk;
   logic                       resetn;
   logic                       miss_valid;
   logic                       miss_ready;
   logic [31:0]                miss_addr;
   logic                       rd_req;
   logic                       rd_rdy;
   logic [31:0]                rd_addr;
   logic                       ret_valid;
   logic                       ret_last;
   logic [31:0]                ret_data;
   logic                       data_we;
   logic [DATA_ADDR_WIDTH-1:0] data_addr;
   logic [31:0]                data_wdata;
   logic                       tag_we;
   logic [INDEX_WIDTH-1:0]     tag_addr;
   logic [TAG_WIDTH:0]         tag_wdata;
   logic                       refill_done;
   logic                       fwd_valid;
   logic [31:0]                fwd_data;
   logic                       err;

   int   total = 0;
   int   bad   = 0;
   int   we_cnt, tag_cnt, done_cnt, acc_cnt;
   logic exp_err;

   cache_refill_ctrl dut (
      .clk         (clk),
      .resetn      (resetn),
      .miss_valid  (miss_valid),
      .miss_ready  (miss_ready),
      .miss_addr   (miss_addr),
      .rd_req      (rd_req),
      .rd_rdy      (rd_rdy),
      .rd_addr     (rd_addr),
      .ret_valid   (ret_valid),
      .ret_last    (ret_last),
      .ret_data    (ret_data),
      .data_we     (data_we),
      .data_addr   (data_addr),
      .data_wdata  (data_wdata),
      .tag_we      (tag_we),
      .tag_addr    (tag_addr),
      .tag_wdata   (tag_wdata),
      .refill_done (refill_done),
      .fwd_valid   (fwd_valid),
      .fwd_data    (fwd_data),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (resetn) begin
         if (data_we)                 we_cnt++;
         if (tag_we)                  tag_cnt++;
         if (refill_done)             done_cnt++;
         if (miss_valid && miss_ready) acc_cnt++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_counts();
      we_cnt = 0; tag_cnt = 0; done_cnt = 0;
   endtask

   task automatic accept(input logic [31:0] addr, input bit hold);
      int waited = 0;
      @(negedge clk);
      miss_valid = 1'b1;
      miss_addr  = addr;
      clear_counts();
      while (!miss_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      total++;
      if (miss_ready !== 1'b1) begin
         $display("FAIL accept_timeout: miss_ready=%b required 1", miss_ready);
         bad++;
      end
      @(negedge clk);
      if (!hold) miss_valid = 1'b0;
   endtask

   // Called on the falling edge right after the miss was accepted; returns on
   // the falling edge of L+2 (one cycle after refill_done).
   task automatic run_refill(input logic [31:0] addr, input int delay, input int gap,
                             input int bad_beat, input logic [31:0] d [4], input string tn);
      logic [31:0]                idx;
      logic [DATA_ADDR_WIDTH-1:0] exp_da;
      logic [TAG_WIDTH:0]         exp_tw;
      int                         woff;
      bit                         exp_fwd;
      idx    = (addr >> 4) & 32'hFF;
      woff   = int'((addr >> 2) & 32'h3);
      exp_tw = (TAG_WIDTH+1)'((32'h1 << TAG_WIDTH) | (addr >> 12));

      total++;
      if (rd_req !== 1'b1 || rd_addr !== (addr & 32'hFFFF_FFF0)) begin
         $display("FAIL %s rd_req/rd_addr: got %b/%h want 1/%h", tn, rd_req, rd_addr, addr & 32'hFFFF_FFF0);
         bad++;
      end
      total++;
      if (miss_ready !== 1'b0) begin
         $display("FAIL %s busy_ready: got %b want 0", tn, miss_ready);
         bad++;
      end

      rd_rdy = 1'b0;
      for (int c = 0; c < delay; c++) begin
         @(negedge clk);
         total++;
         if (rd_req !== 1'b1) begin
            $display("FAIL %s rd_req_hold[%0d]: got %b want 1", tn, c, rd_req);
            bad++;
         end
      end
      rd_rdy = 1'b1;
      @(negedge clk);
      rd_rdy = 1'b0;

      for (int i = 0; i < LINE_WORDS; i++) begin
         for (int g = 0; g < gap; g++) begin
            ret_valid = 1'b0;
            ret_last  = 1'($urandom_range(0, 1));
            @(negedge clk);
         end
         ret_valid = 1'b1;
         ret_data  = d[i];
         ret_last  = (i == LINE_WORDS - 1) ^ (i == bad_beat);
         if (ret_last != (i == LINE_WORDS - 1)) exp_err = 1'b1;
`ifdef REFILL_CRITICAL_WORD_FWD_EN
         exp_fwd = (i == woff);
`else
         exp_fwd = 1'b0;
`endif
         exp_da = DATA_ADDR_WIDTH'(idx * LINE_WORDS + 32'(i));
         @(negedge clk);
         ret_valid = 1'b0;
         ret_last  = 1'b0;

         total++;
         if (data_we !== 1'b1 || data_addr !== exp_da || data_wdata !== d[i]) begin
            $display("FAIL %s write[%0d]: got we=%b addr=%h data=%h want 1/%h/%h",
                     tn, i, data_we, data_addr, data_wdata, exp_da, d[i]);
            bad++;
         end
         total++;
         if (err !== exp_err) begin
            $display("FAIL %s err[%0d]: got %b want %b", tn, i, err, exp_err);
            bad++;
         end
         total++;
         if (fwd_valid !== exp_fwd || (exp_fwd && fwd_data !== d[i])) begin
            $display("FAIL %s fwd[%0d]: got %b/%h want %b/%h", tn, i, fwd_valid, fwd_data, exp_fwd, d[i]);
            bad++;
         end
         total++;
         if (tag_we !== (i == LINE_WORDS - 1) || refill_done !== (i == LINE_WORDS - 1)) begin
            $display("FAIL %s tag_we/done[%0d]: got %b/%b want %b", tn, i, tag_we, refill_done,
                     (i == LINE_WORDS - 1));
            bad++;
         end
         if (i == LINE_WORDS - 1) begin
            total++;
            if (tag_addr !== INDEX_WIDTH'(idx) || tag_wdata !== exp_tw || miss_ready !== 1'b0) begin
               $display("FAIL %s tag: got addr=%h data=%h ready=%b want %h/%h/0",
                        tn, tag_addr, tag_wdata, miss_ready, idx, exp_tw);
               bad++;
            end
         end
      end

      @(negedge clk);
      total++;
      if (miss_ready !== 1'b1 || tag_we !== 1'b0 || data_we !== 1'b0) begin
         $display("FAIL %s after_done: got ready=%b tag_we=%b data_we=%b want 1/0/0",
                  tn, miss_ready, tag_we, data_we);
         bad++;
      end
      total++;
      if (we_cnt != LINE_WORDS || tag_cnt != 1 || done_cnt != 1) begin
         $display("FAIL %s pulse_counts: got we=%0d tag=%0d done=%0d want 4/1/1",
                  tn, we_cnt, tag_cnt, done_cnt);
         bad++;
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0; miss_valid = 1'b0; miss_addr = '0; rd_rdy = 1'b0;
      ret_valid = 1'b0; ret_last = 1'b0; ret_data = '0; exp_err = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (miss_ready !== 1'b1 || rd_req !== 1'b0 || rd_addr !== 32'h0) begin
         $display("FAIL reset_ctrl: got ready=%b rd_req=%b rd_addr=%h want 1/0/0", miss_ready, rd_req, rd_addr);
         bad++;
      end
      total++;
      if (data_we !== 1'b0 || data_addr !== '0 || data_wdata !== 32'h0) begin
         $display("FAIL reset_data: got %b/%h/%h want 0/0/0", data_we, data_addr, data_wdata);
         bad++;
      end
      total++;
      if (tag_we !== 1'b0 || tag_addr !== '0 || tag_wdata !== '0 || refill_done !== 1'b0) begin
         $display("FAIL reset_tag: got %b/%h/%h/%b want all 0", tag_we, tag_addr, tag_wdata, refill_done);
         bad++;
      end
      total++;
      if (err !== 1'b0 || fwd_valid !== 1'b0 || fwd_data !== 32'h0) begin
         $display("FAIL reset_misc: got err=%b fwd=%b/%h want 0", err, fwd_valid, fwd_data);
         bad++;
      end
      resetn = 1'b1;
   endtask

   task automatic test_basic();
      logic [31:0] d [4];
      for (int i = 0; i < 4; i++) d[i] = 32'hA0 + 32'(i);
      accept(32'h1234_5678, 1'b0);
      run_refill(32'h1234_5678, 0, 0, -1, d, "basic");
   endtask

   task automatic test_backpressure();
      logic [31:0] d [4];
      for (int i = 0; i < 4; i++) d[i] = 32'hB0 + 32'(i);
      accept(32'h0ABC_D124, 1'b0);
      run_refill(32'h0ABC_D124, 5, 2, -1, d, "backpressure");
   endtask

   task automatic test_crit_word();
      logic [31:0] d [4];
      for (int i = 0; i < 4; i++) d[i] = 32'hA0 + 32'(i);
      accept(32'h1234_5678, 1'b0);
      run_refill(32'h1234_5678, 1, 1, -1, d, "crit_word");
   endtask

   task automatic test_mismatch();
      logic [31:0] d [4];
      for (int i = 0; i < 4; i++) d[i] = 32'hC0 + 32'(i);
      accept(32'h5555_0010, 1'b0);
      run_refill(32'h5555_0010, 0, 0, 1, d, "mismatch");
      accept(32'h6666_0020, 1'b0);
      run_refill(32'h6666_0020, 0, 1, -1, d, "mismatch_sticky");
   endtask

   task automatic test_reset_mid();
      accept(32'h7777_7740, 1'b0);
      rd_rdy = 1'b1;
      @(negedge clk);
      rd_rdy = 1'b0;
      for (int i = 0; i < 2; i++) begin
         ret_valid = 1'b1; ret_data = 32'hD0 + 32'(i); ret_last = 1'b0;
         @(negedge clk);
      end
      ret_valid = 1'b0;
      #2 resetn = 1'b0;
      exp_err = 1'b0;
      #1;
      total++;
      if (data_we !== 1'b0 || tag_we !== 1'b0 || refill_done !== 1'b0 || miss_ready !== 1'b1) begin
         $display("FAIL reset_mid_ctrl: got we=%b tag_we=%b done=%b ready=%b want 0/0/0/1",
                  data_we, tag_we, refill_done, miss_ready);
         bad++;
      end
      total++;
      if (rd_addr !== 32'h0 || data_addr !== '0 || data_wdata !== 32'h0 || err !== 1'b0) begin
         $display("FAIL reset_mid_regs: got %h/%h/%h/%b want 0", rd_addr, data_addr, data_wdata, err);
         bad++;
      end
      @(negedge clk);
      resetn = 1'b1;
      clear_counts();
      for (int i = 0; i < 6; i++) begin
         ret_valid = 1'b1; ret_data = $urandom; ret_last = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      ret_valid = 1'b0; ret_last = 1'b0;
      total++;
      if (we_cnt != 0 || tag_cnt != 0 || done_cnt != 0 || miss_ready !== 1'b1 || err !== 1'b0) begin
         $display("FAIL reset_mid_stray: got we=%0d tag=%0d done=%0d ready=%b err=%b want 0/0/0/1/0",
                  we_cnt, tag_cnt, done_cnt, miss_ready, err);
         bad++;
      end
   endtask

   task automatic test_miss_held();
      logic [31:0] d [4];
      logic [31:0] a1, a2;
      a1 = 32'h1111_2220;
      a2 = 32'h3333_444C;
      for (int i = 0; i < 4; i++) d[i] = 32'hE0 + 32'(i);
      acc_cnt = 0;
      accept(a1, 1'b1);
      miss_addr = a2;
      run_refill(a1, 2, 1, -1, d, "held_first");
      @(negedge clk);
      miss_valid = 1'b0;
      clear_counts();
      total++;
      if (acc_cnt != 2 || miss_ready !== 1'b0) begin
         $display("FAIL held_accept: got acc=%0d ready=%b want 2/0", acc_cnt, miss_ready);
         bad++;
      end
      for (int i = 0; i < 4; i++) d[i] = 32'hF0 + 32'(i);
      run_refill(a2, 0, 0, -1, d, "held_second");
      repeat (3) @(negedge clk);
      total++;
      if (acc_cnt != 2) begin
         $display("FAIL held_once: got acc=%0d want 2", acc_cnt);
         bad++;
      end
   endtask

   task automatic test_random();
      logic [31:0] d [4];
      logic [31:0] a;
      int          bb;
      for (int n = 0; n < 20; n++) begin
         a = $urandom;
         for (int i = 0; i < 4; i++) d[i] = $urandom;
         bb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
         accept(a, 1'b0);
         run_refill(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), bb, d, "random");
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_crit_word();
      test_reset_mid();
      test_miss_held();
      test_mismatch();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
